area_accumulator: RTL and testbench

AREA_ACCUMULATOR -- requirements
Module: area_accumulator

---
 rtl/area_accumulator.sv | 122 ++++++++++++
 tb/tb_area_accumulator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/area_accumulator.sv
// Frame accumulator for Sphere_To_Cart area samples: sums FRAME_LEN samples, reports sum and mean.
// Optional per-frame min/max outputs are enabled by defining AREA_ACC_MINMAX_EN.
module area_accumulator #(
    parameter int AREA_W    = 26,
    parameter int FRAME_LEN = 16,
    localparam int LOG2     = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [AREA_W-1:0]      area,
    input  logic                   area_vld,
    output logic [AREA_W+LOG2-1:0] sum,
    output logic [AREA_W-1:0]      avg,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   ovr,
`ifdef AREA_ACC_MINMAX_EN
    output logic [AREA_W-1:0]      min_area,
    output logic [AREA_W-1:0]      max_area,
`endif
    output logic                   busy
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state, next_state;

    logic [AREA_W+LOG2-1:0] acc;
    logic [LOG2-1:0]        cnt;
    logic [AREA_W+LOG2-1:0] frame_total;
    logic                   accept;
    logic                   last;
    logic                   load;

    // NOTE: async reset goes in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE:  if (en)  next_state = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (!en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept      = (state == ACCUM) && en && area_vld;
    assign last        = accept && (cnt == LOG2'(FRAME_LEN - 1));
    // A completed frame only replaces the result if the old one is gone or acknowledged now.
    assign load        = last && (!out_vld || out_rdy);
    assign frame_total = acc + {{LOG2{1'b0}}, area};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (!en || state == IDLE) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= last ? '0 : frame_total;
            cnt <= cnt + LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum     <= '0;
            avg     <= '0;
            out_vld <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (load) begin
                sum     <= frame_total;
                avg     <= frame_total[AREA_W+LOG2-1:LOG2];
                out_vld <= 1'b1;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            if (last && out_vld && !out_rdy) ovr <= 1'b1;
        end
    end

`ifdef AREA_ACC_MINMAX_EN
    logic [AREA_W-1:0] run_min, run_max;
    logic [AREA_W-1:0] cur_min, cur_max;

    // The first sample of a frame seeds the running extremes, so no explicit clear is needed.
    assign cur_min = (cnt == '0 || area < run_min) ? area : run_min;
    assign cur_max = (cnt == '0 || area > run_max) ? area : run_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_min  <= '1;
            run_max  <= '0;
            min_area <= '1;
            max_area <= '0;
        end else begin
            if (accept) begin
                run_min <= cur_min;
                run_max <= cur_max;
            end
            if (load) begin
                min_area <= cur_min;
                max_area <= cur_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_area_accumulator.sv
// Directed self-checking bench for area_accumulator with hand-computed expected values.
module tb_area_accumulator;

    localparam int AREA_W    = 26;
    localparam int FRAME_LEN = 16;
    localparam int LOG2      = 4;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [AREA_W-1:0]      area;
    logic                   area_vld;
    logic [AREA_W+LOG2-1:0] sum;
    logic [AREA_W-1:0]      avg;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   ovr;
    logic                   busy;
`ifdef AREA_ACC_MINMAX_EN
    logic [AREA_W-1:0]      min_area;
    logic [AREA_W-1:0]      max_area;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    area_accumulator #(
        .AREA_W   (AREA_W),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .area    (area),
        .area_vld(area_vld),
        .sum     (sum),
        .avg     (avg),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .ovr     (ovr),
`ifdef AREA_ACC_MINMAX_EN
        .min_area(min_area),
        .max_area(max_area),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called just after a falling edge; presents one sample per cycle.
    task automatic send(input int n, input logic [AREA_W-1:0] val);
        for (int i = 0; i < n; i++) begin
            area     = val;
            area_vld = 1'b1;
            @(negedge clk);
        end
        area_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        area     = '0;
        area_vld = 1'b0;
        out_rdy  = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_sum",     sum,     0);
        check("rst_avg",     avg,     0);
        check("rst_out_vld", out_vld, 0);
        check("rst_ovr",     ovr,     0);
        check("rst_busy",    busy,    0);
`ifdef AREA_ACC_MINMAX_EN
        check("rst_min", min_area, 64'h3FF_FFFF);
        check("rst_max", max_area, 0);
`endif

        // Basic frame of 16 x 1000.
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        check("busy_accum", busy, 1);
        send(15, 1000);
        check("mid_frame_vld", out_vld, 0);
        send(1, 1000);
        check("f1_vld", out_vld, 1);
        check("f1_sum", sum, 16000);
        check("f1_avg", avg, 1000);
        @(negedge clk);
        check("f1_vld_clr", out_vld, 0);

        // Mixed frame with truncating mean.
        send(4, 1000);
        send(4, 2000);
        send(4, 4000);
        send(4, 250);
        check("f2_vld", out_vld, 1);
        check("f2_sum", sum, 29000);
        check("f2_avg", avg, 1812);
`ifdef AREA_ACC_MINMAX_EN
        check("f2_min", min_area, 250);
        check("f2_max", max_area, 4000);
`endif

        // Full-scale samples must not wrap.
        send(16, 26'h3FF_FFFF);
        check("f3_sum", sum, 64'h3FFF_FFF0);
        check("f3_avg", avg, 64'h3FF_FFFF);

        // Completion coinciding with acknowledge: new result loads, no overrun.
        do_reset();
        en = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        send(16, 10);
        check("f4_sum", sum, 160);
        check("f4_vld", out_vld, 1);
        send(15, 20);
        out_rdy = 1'b1;
        send(1, 20);
        check("f5_sum", sum, 320);
        check("f5_avg", avg, 20);
        check("f5_vld", out_vld, 1);
        check("f5_ovr", ovr, 0);
        @(negedge clk);
        check("f5_vld_clr", out_vld, 0);

        // Overrun: second frame is dropped while result is unacknowledged.
        out_rdy = 1'b0;
        send(16, 100);
        check("f6_sum", sum, 1600);
        check("f6_ovr", ovr, 0);
        send(16, 200);
        check("ovr_sum_kept", sum, 1600);
        check("ovr_avg_kept", avg, 100);
        check("ovr_set", ovr, 1);
        check("ovr_vld", out_vld, 1);
        out_rdy = 1'b1;
        @(negedge clk);
        check("ovr_vld_clr", out_vld, 0);
        check("ovr_sticky", ovr, 1);

        // Partial frame discarded by en dropping for one cycle.
        send(5, 9000);
        en = 1'b0;
        @(negedge clk);
        check("en_low_busy", busy, 0);
        en = 1'b1;
        @(negedge clk);
        send(16, 500);
        check("f7_sum", sum, 8000);
        check("f7_avg", avg, 500);
        check("f7_ovr", ovr, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a frame.
        send(7, 250);
        #3;
        rst = 1'b0;
        #1;
        check("arst_sum",  sum,     0);
        check("arst_avg",  avg,     0);
        check("arst_vld",  out_vld, 0);
        check("arst_ovr",  ovr,     0);
        check("arst_busy", busy,    0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(16, 250);
        check("f8_sum", sum, 4000);
        check("f8_avg", avg, 250);
        check("f8_vld", out_vld, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
